// File: rtl/spi_banco_registros_if.sv
// Bus bundle between spi_banco_registros, the CPU bus and the SPI control interface.
// The slave modport is the register bank; the master modport is whatever drives it.
interface spi_banco_registros_if #(
    parameter int unsigned AW = 10
);
    // CPU side
    logic          we_ctrl_i;
    logic          we_data_i;
    logic [AW-1:0] addr_i;
    logic [31:0]   wdata_i;
    logic [31:0]   rdata_ctrl_o;
    logic [31:0]   rdata_data_o;
    logic          stall_o;

    // SPI control interface side
    logic          hold_ctrl_i;
    logic [AW-1:0] addr2_i;
    logic          wr2_data_i;
    logic [31:0]   in2_data_i;
    logic          wr2_ctrl_i;
    logic [31:0]   in2_ctrl_i;
    logic [31:0]   out_ctrl_o;
    logic [31:0]   out_dato_o;

    modport slave (
        input  we_ctrl_i, we_data_i, addr_i, wdata_i,
        input  hold_ctrl_i, addr2_i, wr2_data_i, in2_data_i, wr2_ctrl_i, in2_ctrl_i,
        output rdata_ctrl_o, rdata_data_o, stall_o, out_ctrl_o, out_dato_o
    );

    modport master (
        output we_ctrl_i, we_data_i, addr_i, wdata_i,
        output hold_ctrl_i, addr2_i, wr2_data_i, in2_data_i, wr2_ctrl_i, in2_ctrl_i,
        input  rdata_ctrl_o, rdata_data_o, stall_o, out_ctrl_o, out_dato_o
    );
endinterface

// File: rtl/spi_banco_registros.sv
// SPI control register plus word-addressed data buffer, sharing one write port between the
// CPU bus and the SPI control interface via one-entry pending buffers and a CPU stall.
module spi_banco_registros #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input logic                  clk_i,
    input logic                  rst_i,
    spi_banco_registros_if.slave bus
);
    // Bits [25:16] hold the rx word count, owned by the SPI side.
    localparam logic [31:0] HwMask = 32'h03FF_0000;

    logic [31:0]   mem_q [DEPTH];

    logic [31:0]   ctrl_q,         ctrl_d;
    logic          pend_c_valid_q, pend_c_valid_d;
    logic [31:0]   pend_c_data_q,  pend_c_data_d;
    logic          pend_d_valid_q, pend_d_valid_d;
    logic [AW-1:0] pend_d_addr_q,  pend_d_addr_d;
    logic [31:0]   pend_d_data_q,  pend_d_data_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    logic          stall_data;
    logic          stall_ctrl;

    function automatic logic [31:0] cpu_merge(input logic [31:0] wr, input logic [31:0] cur);
        return (wr & ~HwMask) | (cur & HwMask);
    endfunction

    assign stall_data = bus.we_data_i && pend_d_valid_q;
    assign stall_ctrl = bus.we_ctrl_i && pend_c_valid_q;

    assign bus.stall_o      = stall_data || stall_ctrl;
    assign bus.out_ctrl_o   = ctrl_q;
    assign bus.rdata_ctrl_o = ctrl_q;
    assign bus.out_dato_o   = mem_q[bus.addr2_i];
    assign bus.rdata_data_o = (pend_d_valid_q && (bus.addr_i == pend_d_addr_q)) ?
                              pend_d_data_q : mem_q[bus.addr_i];

    // Buffer write port arbitration
    always_comb begin
        mem_we         = 1'b0;
        mem_waddr      = bus.addr_i;
        mem_wdata      = bus.wdata_i;
        pend_d_valid_d = pend_d_valid_q;
        pend_d_addr_d  = pend_d_addr_q;
        pend_d_data_d  = pend_d_data_q;

        if (bus.hold_ctrl_i) begin
            mem_we    = bus.wr2_data_i;
            mem_waddr = bus.addr2_i;
            mem_wdata = bus.in2_data_i;
            if (bus.we_data_i && !pend_d_valid_q) begin
                pend_d_valid_d = 1'b1;
                pend_d_addr_d  = bus.addr_i;
                pend_d_data_d  = bus.wdata_i;
            end
        end else if (pend_d_valid_q) begin
            // A CPU write arriving now is stalled and retried next cycle.
            mem_we         = 1'b1;
            mem_waddr      = pend_d_addr_q;
            mem_wdata      = pend_d_data_q;
            pend_d_valid_d = 1'b0;
        end else begin
            mem_we = bus.we_data_i;
        end

        if (rst_i) begin
            mem_we         = 1'b0;
            pend_d_valid_d = 1'b0;
        end
    end

    // Control register arbitration
    always_comb begin
        ctrl_d         = ctrl_q;
        pend_c_valid_d = pend_c_valid_q;
        pend_c_data_d  = pend_c_data_q;

        if (bus.wr2_ctrl_i) begin
            ctrl_d = bus.in2_ctrl_i;
            if (bus.we_ctrl_i && !pend_c_valid_q) begin
                pend_c_valid_d = 1'b1;
                pend_c_data_d  = bus.wdata_i;
            end
        end else if (pend_c_valid_q) begin
            ctrl_d         = cpu_merge(pend_c_data_q, ctrl_q);
            pend_c_valid_d = 1'b0;
        end else if (bus.we_ctrl_i) begin
            ctrl_d = cpu_merge(bus.wdata_i, ctrl_q);
        end

        if (rst_i) begin
            ctrl_d         = '0;
            pend_c_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        ctrl_q         <= ctrl_d;
        pend_c_valid_q <= pend_c_valid_d;
        pend_c_data_q  <= pend_c_data_d;
        pend_d_valid_q <= pend_d_valid_d;
        pend_d_addr_q  <= pend_d_addr_d;
        pend_d_data_q  <= pend_d_data_d;
    end

    // Buffer contents survive reset; only the write is suppressed while rst_i is high.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: doc/spi_banco_registros.md
Name: spi_banco_registros

Overview:
- Register/buffer stage directly upstream of the SPI control interface.
- Holds the 32-bit SPI control register and a word-addressed transmit/receive data buffer.
- Drives out_ctrl_o/out_dato_o into the SPI control interface and accepts its write-back port (addr2, wr2_data, in2_data, wr2_ctrl, in2_ctrl, hold_ctrl).
- Arbitrates that port against CPU bus writes through one-entry pending buffers and a stall signal.

Parameters:
DEPTH, 1024, data buffer depth in 32-bit words
AW, 10, buffer address width; must satisfy 2**AW == DEPTH

Ports:
clk_i  in  1  system clock (10 MHz)
rst_i  in  1  synchronous reset, active-high
we_ctrl_i  in  1  CPU write strobe, control register
we_data_i  in  1  CPU write strobe, data buffer
addr_i  in  AW  CPU data buffer address
wdata_i  in  32  CPU write data
rdata_ctrl_o  out  32  CPU read of control register
rdata_data_o  out  32  CPU read of mem[addr_i], with forwarding
stall_o  out  1  CPU write not accepted this cycle; hold strobe and retry
hold_ctrl_i  in  1  SPI side owns the buffer write port
addr2_i  in  AW  SPI-side buffer address
wr2_data_i  in  1  SPI-side buffer write enable
in2_data_i  in  32  SPI-side buffer write data
wr2_ctrl_i  in  1  SPI-side control register write enable
in2_ctrl_i  in  32  SPI-side control register write data
out_ctrl_o  out  32  control register contents
out_dato_o  out  32  mem[addr2_i]

Behaviour:
- Clock, reset: single clock clk_i. rst_i is synchronous, active-high.
- Reset effects:
  - ctrl register = 0.
  - pend_d_valid = 0, pend_c_valid = 0.
  - stall_o = 0.
  - Buffer contents are not reset.
- Control register map:
  - [0] send
  - [1] cs enable (cs = ~bit1 downstream)
  - [2] all-ones
  - [3] all-zeros
  - [12:4] n_tx_end
  - [15:13] and [31:26] stored as written
  - [25:16] rx word count, hardware-owned
- CPU control write applies all bits except [25:16], which keep their current value.
- SPI control write (wr2_ctrl_i) loads all 32 bits from in2_ctrl_i.
- Write latency: all writes are visible on outputs the cycle after the accepting edge.
- Reads:
  - Buffer reads are combinational (two async read ports).
  - out_ctrl_o = rdata_ctrl_o = ctrl register; pending values are not visible.
  - out_dato_o = mem[addr2_i] always.
  - rdata_data_o = pend_d_data if pend_d_valid && addr_i == pend_d_addr, else mem[addr_i].
- Buffer write port, priority per cycle:
  1. hold_ctrl_i=1: only wr2_data_i writes in2_data_i to mem[addr2_i].
  2. hold_ctrl_i=0 and pend_d_valid: commit pending to mem[pend_d_addr], clear pend_d_valid.
  3. hold_ctrl_i=0, no pending, we_data_i: write wdata_i to mem[addr_i] directly.
- CPU data write while hold_ctrl_i=1 and !pend_d_valid: captured into pend_d_{addr,data}, pend_d_valid=1, no stall.
- stall_o = (we_data_i && pend_d_valid) || (we_ctrl_i && pend_c_valid). Combinational; stalled writes have no effect.
- When hold drops while pending and a new CPU write arrives in the same cycle:
  - the pending entry commits;
  - the new write is stalled;
  - the retried write is accepted the following cycle.
- wr2_data_i while hold_ctrl_i=0 is ignored (protocol error, no effect).
- Control register, per cycle:
  - wr2_ctrl_i && we_ctrl_i && !pend_c_valid: SPI value written; CPU value into pend_c.
  - wr2_ctrl_i only: SPI value written.
  - !wr2_ctrl_i && pend_c_valid: pending CPU value applied (merge rule above), cleared.
  - !wr2_ctrl_i && we_ctrl_i && !pend_c_valid: CPU value applied.
- Reset asserted mid-operation discards pending entries and returns stall_o to 0 on the next edge.
- Address arithmetic: unsigned; addresses ≥ DEPTH cannot occur because 2**AW == DEPTH.

Test Plan:
- Reset, then CPU we_ctrl_i wdata_i=0x0000_0053 → out_ctrl_o=0x0000_0053 next cycle. Then wdata_i=0xFFFF_FFFF → out_ctrl_o=0xFC00_FFFF ([25:16] stays 0).
- hold=0, CPU write 0xA5 to addr 5 → rdata_data_o=0xA5. hold=1, addr2_i=5 → out_dato_o=0xA5. wr2_data_i in2_data_i=0x3C at addr2 7 → mem[7]=0x3C.
- hold=1, CPU write 0x11 to addr 9 → stall_o=0; rdata_data_o(addr 9)=0x11 via forwarding; mem[9] unchanged. Second write → stall_o=1. hold→0 → mem[9]=0x11 one cycle later.
- Same cycle: wr2_ctrl_i in2_ctrl=0x0005_0010 and we_ctrl_i 0x0000_0013 → out_ctrl_o=0x0005_0010. Next cycle (wr2 low) → 0x0005_0013.
- hold=0 with pending and we_data_i → stall_o=1 exactly one cycle; retry accepted; both addresses hold correct data.
- rst_i mid-hold with pending data and ctrl → ctrl=0, pending discarded, mem[pend_addr] unchanged, stall_o=0.
